// File: rtl/ufp_div_seq_pkg.sv
// Shared types and derived-width helpers for the unsigned fixed-point divider.
package ufp_div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  // Left shift that aligns the numerator so the integer quotient lands in QIW.QQW.
  function automatic int calc_s(input int aqw, input int bqw, input int qqw);
    return bqw + qqw - aqw;
  endfunction

  function automatic int calc_nw(input int aiw, input int aqw, input int bqw, input int qqw);
    int s;
    s = calc_s(aqw, bqw, qqw);
    return aiw + aqw + ((s > 0) ? s : 0);
  endfunction

endpackage

// File: rtl/ufp_div_seq_if.sv
// Operand/result handshake bundle for ufp_div_seq.
interface ufp_div_seq_if #(
  parameter int AWL = 16,
  parameter int BWL = 16,
  parameter int QWL = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [AWL-1:0] a;
  logic [BWL-1:0] b;
  logic           out_valid;
  logic           out_ready;
  logic [QWL-1:0] q;
  logic           overflow;
  logic           div_zero;

  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, q, overflow, div_zero);
  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, q, overflow, div_zero);
endinterface

// File: rtl/ufp_div_seq_clip.sv
// Unsigned saturating narrow: any set bit above OUTW forces all ones and flags a clip.
module clip_unsigned #(
  parameter int INW  = 24,
  parameter int OUTW = 16
) (
  input  logic [INW-1:0]  x_i,
  output logic [OUTW-1:0] y_o,
  output logic            clip_o
);
  if (INW > OUTW) begin : g_narrow
    assign clip_o = |x_i[INW-1:OUTW];
    assign y_o    = clip_o ? '1 : x_i[OUTW-1:0];
  end else begin : g_wide
    assign clip_o = 1'b0;
    assign y_o    = OUTW'(x_i);
  end
endmodule

// File: rtl/ufp_div_seq.sv
// Radix-2 restoring divider for unsigned fixed point: q = floor((a aligned) / b),
// one quotient bit per cycle, saturating to QIW.QQW.
module ufp_div_seq
  import ufp_div_pkg::*;
#(
  parameter int AIW = 8,
  parameter int AQW = 8,
  parameter int BIW = 8,
  parameter int BQW = 8,
  parameter int QIW = 8,
  parameter int QQW = 8
) (
  input  logic          clk,
  input  logic          rst,
  ufp_div_seq_if.slave  io
);
  localparam int S   = calc_s(AQW, BQW, QQW);
  localparam int NW  = calc_nw(AIW, AQW, BQW, QQW);
  localparam int BWL = BIW + BQW;
  localparam int QWL = QIW + QQW;
  localparam int SL  = (S > 0) ? S : 0;
  localparam int SR  = (S < 0) ? -S : 0;
  localparam int CW  = (NW > 1) ? $clog2(NW) : 1;

  state_e          state_q;
  logic [NW-1:0]   num_q, quo_q, quo_d, num_init;
  logic [BWL-1:0]  den_q;
  logic [BWL:0]    rem_q, rem_d, rem_sh, trial;
  logic [CW-1:0]   cnt_q;
  logic            dz_q, qbit;
  logic            out_valid_q, ov_q, dzo_q;
  logic [QWL-1:0]  q_q, clip_y;
  logic            clip_ov;
  logic            unused_rem_msb;

  // A negative alignment drops numerator LSBs, which is what truncation wants.
  assign num_init = (NW'(io.a) << SL) >> SR;

  // Remainder is always below the divisor, so its top bit only matters mid-subtract.
  assign unused_rem_msb = rem_q[BWL];

  always_comb begin
    rem_sh = {rem_q[BWL-1:0], num_q[NW-1]};
    trial  = rem_sh - {1'b0, den_q};
    qbit   = (rem_sh >= {1'b0, den_q});
    rem_d  = qbit ? trial : rem_sh;
    quo_d  = {quo_q[NW-2:0], qbit};
  end

  clip_unsigned #(.INW(NW), .OUTW(QWL)) u_clip (
    .x_i    (quo_d),
    .y_o    (clip_y),
    .clip_o (clip_ov)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      num_q       <= '0;
      quo_q       <= '0;
      den_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      dz_q        <= 1'b0;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      ov_q        <= 1'b0;
      dzo_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (io.in_valid) begin
          num_q   <= num_init;
          den_q   <= io.b;
          dz_q    <= (io.b == '0);
          rem_q   <= '0;
          quo_q   <= '0;
          cnt_q   <= CW'(NW - 1);
          state_q <= CALC;
        end
        CALC: begin
          num_q <= num_q << 1;
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            q_q         <= dz_q ? '1 : clip_y;
            ov_q        <= !dz_q && clip_ov;
            dzo_q       <= dz_q;
          end
        end
        DONE: if (io.out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = (state_q == IDLE) && !rst;
  assign io.out_valid = out_valid_q;
  assign io.q         = q_q;
  assign io.overflow  = ov_q;
  assign io.div_zero  = dzo_q;
endmodule

// File: tb/tb_ufp_div_seq.sv
// Directed bench for ufp_div_seq at default 8.8 formats (NW = 24).
module tb_ufp_div_seq;
  import ufp_div_pkg::*;

  localparam int NW = calc_nw(8, 8, 8, 8);

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  ufp_div_seq_if #(.AWL(16), .BWL(16), .QWL(16)) dif ();

  ufp_div_seq #(.AIW(8), .AQW(8), .BIW(8), .BQW(8), .QIW(8), .QQW(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (dif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one operand pair, then scramble the operand lines while busy.
  task automatic issue(input logic [15:0] av, input logic [15:0] bv);
    int g;
    g = 0;
    while (!dif.in_ready && g < 60) begin
      @(posedge clk); #1; g++;
    end
    chk("in_ready_idle", 32'(dif.in_ready), 32'd1);
    dif.a = av; dif.b = bv; dif.in_valid = 1'b1;
    @(posedge clk); #1;
    dif.in_valid = 1'b0; dif.a = ~av; dif.b = ~bv;
    chk("in_ready_busy", 32'(dif.in_ready), 32'd0);
  endtask

  // Latency counts the accept cycle, so out_valid after edge T+NW gives NW+1.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] eq, input logic eov, input logic edz);
    int cyc;
    issue(av, bv);
    cyc = 1;
    while (!dif.out_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(NW + 1));
    chk({tag, "_q"}, 32'(dif.q), 32'(eq));
    chk({tag, "_ovf"}, 32'(dif.overflow), 32'(eov));
    chk({tag, "_dz"}, 32'(dif.div_zero), 32'(edz));
  endtask

  task automatic release_out();
    dif.out_ready = 1'b1;
    @(posedge clk); #1;
    dif.out_ready = 1'b0;
    chk("release_out_valid", 32'(dif.out_valid), 32'd0);
    chk("release_in_ready", 32'(dif.in_ready), 32'd1);
  endtask

  initial begin
    logic stale;
    rst = 1'b1;
    dif.in_valid = 1'b0; dif.a = '0; dif.b = '0; dif.out_ready = 1'b0;
    #2;
    chk("rst_in_ready", 32'(dif.in_ready), 32'd0);
    chk("rst_out_valid", 32'(dif.out_valid), 32'd0);
    chk("rst_q", 32'(dif.q), 32'd0);
    chk("rst_ovf", 32'(dif.overflow), 32'd0);
    chk("rst_dz", 32'(dif.div_zero), 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(dif.in_ready), 32'd1);

    run_op("one_by_two", 16'h0100, 16'h0200, 16'h0080, 1'b0, 1'b0);   release_out();
    run_op("three_by_half", 16'h0300, 16'h0080, 16'h0600, 1'b0, 1'b0); release_out();
    run_op("one_by_three", 16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0);  release_out();
    run_op("big_by_lsb", 16'hFF00, 16'h0001, 16'hFFFF, 1'b1, 1'b0);    release_out();
    run_op("div_zero", 16'h1234, 16'h0000, 16'hFFFF, 1'b0, 1'b1);      release_out();
    // Exactly the largest representable quotient, and one past it.
    run_op("max_fit", 16'hFFFF, 16'h0100, 16'hFFFF, 1'b0, 1'b0);       release_out();
    run_op("just_over", 16'h0100, 16'h0001, 16'hFFFF, 1'b1, 1'b0);     release_out();
    run_op("zero_num", 16'h0000, 16'h0100, 16'h0000, 1'b0, 1'b0);      release_out();

    run_op("bp", 16'h0300, 16'h0080, 16'h0600, 1'b0, 1'b0);
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_q_hold", 32'(dif.q), 32'h0600);
      chk("bp_valid_hold", 32'(dif.out_valid), 32'd1);
      chk("bp_in_ready", 32'(dif.in_ready), 32'd0);
    end
    release_out();

    issue(16'h0100, 16'h0300);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(dif.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(dif.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("after_rst_in_ready", 32'(dif.in_ready), 32'd1);
    stale = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (dif.out_valid) stale = 1'b1;
    end
    chk("no_stale_result", 32'(stale), 32'd0);
    run_op("after_rst", 16'h0100, 16'h0200, 16'h0080, 1'b0, 1'b0);
    release_out();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
